// File: rtl/can_tx_sched_if.sv
// Requester / CAN TX word-stream bundle for can_tx_sched.
// slave: scheduler side; master: requesters plus the CAN top.
interface can_tx_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_data;
    logic               can_tx_valid;
    logic               can_tx_ready;
    logic [31:0]        can_tx_data;
    logic [3:0]         last_src;
    logic               hb_overrun;

    modport slave (
        input  req_valid, req_data, can_tx_ready,
        output req_ready, can_tx_valid, can_tx_data, last_src, hb_overrun
    );

    modport master (
        output req_valid, req_data, can_tx_ready,
        input  req_ready, can_tx_valid, can_tx_data, last_src, hb_overrun
    );
endinterface

// File: rtl/can_tx_sched.sv
// Round-robin TX word scheduler with a one-deep output stage.
// Heartbeat injection is built only with CAN_TX_SCHED_HEARTBEAT_EN.
module can_tx_sched #(
    parameter int          NREQ      = 4,
    parameter logic [31:0] HB_PERIOD = 32'd1000000,
    parameter logic [7:0]  HB_TAG    = 8'hA5
) (
    input logic           clk,
    input logic           rstn,
    can_tx_sched_if.slave bus
);
    localparam int IW = $clog2(NREQ);

    logic          out_valid_q, out_valid_d;
    logic [31:0]   can_tx_data_q, can_tx_data_d;
    logic [3:0]    last_src_q, last_src_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    logic          load_en;
    logic          found;
    logic [IW-1:0] win;
    logic [IW:0]   idx;
    logic          hb_pending;
    logic [7:0]    hb_seq;

    assign load_en = ~out_valid_q | bus.can_tx_ready;

    // Scan from rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (IW + 1)'(k);
            if (idx >= (IW + 1)'(NREQ)) begin
                idx = idx - (IW + 1)'(NREQ);
            end
            if (!found && bus.req_valid[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        can_tx_data_d = can_tx_data_q;
        last_src_d    = last_src_q;
        rr_ptr_d      = rr_ptr_q;
        bus.req_ready = '0;
        if (load_en) begin
            if (hb_pending) begin
                out_valid_d   = 1'b1;
                can_tx_data_d = {HB_TAG, hb_seq, 16'h0000};
                last_src_d    = 4'hF;
            end else if (found) begin
                out_valid_d        = 1'b1;
                can_tx_data_d      = bus.req_data[32*win +: 32];
                last_src_d         = 4'(win);
                rr_ptr_d           = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
                bus.req_ready[win] = rstn;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q   <= 1'b0;
            can_tx_data_q <= '0;
            last_src_q    <= 4'h0;
            rr_ptr_q      <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            can_tx_data_q <= can_tx_data_d;
            last_src_q    <= last_src_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign bus.can_tx_valid = out_valid_q;
    assign bus.can_tx_data  = can_tx_data_q;
    assign bus.last_src     = last_src_q;

`ifdef CAN_TX_SCHED_HEARTBEAT_EN
    logic [31:0] hb_cnt_q, hb_cnt_d;
    logic [7:0]  hb_seq_q, hb_seq_d;
    logic        hb_pending_q, hb_pending_d;
    logic        hb_overrun_q, hb_overrun_d;
    logic        hb_tick;

    // A tick while the pending heartbeat cannot load is dropped and flagged.
    always_comb begin
        hb_tick      = (hb_cnt_q == HB_PERIOD - 32'd1);
        hb_cnt_d     = hb_tick ? '0 : hb_cnt_q + 32'd1;
        hb_pending_d = hb_tick | (hb_pending_q & ~load_en);
        hb_overrun_d = hb_tick & hb_pending_q & ~load_en;
        hb_seq_d     = hb_seq_q;
        if (hb_pending_q && load_en) begin
            hb_seq_d = hb_seq_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hb_cnt_q     <= '0;
            hb_seq_q     <= '0;
            hb_pending_q <= 1'b0;
            hb_overrun_q <= 1'b0;
        end else begin
            hb_cnt_q     <= hb_cnt_d;
            hb_seq_q     <= hb_seq_d;
            hb_pending_q <= hb_pending_d;
            hb_overrun_q <= hb_overrun_d;
        end
    end

    assign hb_pending     = hb_pending_q;
    assign hb_seq         = hb_seq_q;
    assign bus.hb_overrun = hb_overrun_q;
`else
    logic unused_hb_period;

    assign hb_pending       = 1'b0;
    assign hb_seq           = 8'h00;
    assign bus.hb_overrun   = 1'b0;
    assign unused_hb_period = ^HB_PERIOD;
`endif
endmodule

// File: tb/tb_can_tx_sched.sv
// Self-checking bench for can_tx_sched against a cycle-level
// behavioural model of the scheduler, output stage and heartbeat.
module tb_can_tx_sched;
    localparam int          NREQ      = 4;
    localparam int          HB_PERIOD = 16;
    localparam logic [7:0]  HB_TAG    = 8'hA5;
`ifdef CAN_TX_SCHED_HEARTBEAT_EN
    localparam bit HB_ON = 1'b1;
`else
    localparam bit HB_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;

    can_tx_sched_if #(.NREQ(NREQ)) bus ();

    can_tx_sched #(
        .NREQ(NREQ),
        .HB_PERIOD(HB_PERIOD),
        .HB_TAG(HB_TAG)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int          m_ptr;
    bit          m_pend;
    logic [7:0]  m_seq;
    int          m_cyc;
    bit          m_ov;
    logic [31:0] m_data;
    logic [3:0]  m_src;
    bit          m_ovr;

    bit          rv[NREQ];
    bit          hold[NREQ];
    logic [31:0] rd[NREQ];

    int          out_log[$];
    logic [31:0] hb_log[$];
    int          n_ovr_seen;

    task automatic do_reset();
        rstn = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.can_tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        m_ptr = 0;
        m_pend = 1'b0;
        m_seq = 8'h00;
        m_cyc = 0;
        m_ov = 1'b0;
        m_data = '0;
        m_src = 4'h0;
        m_ovr = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b0;
            hold[i] = 1'b0;
            rd[i] = '0;
        end
        out_log.delete();
        hb_log.delete();
        n_ovr_seen = 0;
    endtask

    // Cycle-by-cycle traffic against the model; vpct/rpct are percentages.
    task automatic run_model(input int ncyc, input int vpct, input int rpct);
        for (int c = 0; c < ncyc; c++) begin
            bit             load;
            bit             tick;
            bit             nxt_ovr;
            bit             rdy;
            int             w;
            logic [NREQ-1:0] exp_rdy;
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (!hold[i]) begin
                    rv[i] = ($urandom_range(99) < vpct);
                    rd[i] = $urandom;
                    hold[i] = rv[i];
                end
                bus.req_valid[i] = rv[i];
                bus.req_data[32*i +: 32] = rd[i];
            end
            rdy = ($urandom_range(99) < rpct);
            bus.can_tx_ready = rdy;
            #1;
            load = !m_ov || rdy;
            tick = HB_ON && ((m_cyc % HB_PERIOD) == HB_PERIOD - 1);
            w = -1;
            if (!m_pend) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && rv[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                end
            end
            exp_rdy = '0;
            if (load && w >= 0) exp_rdy[w] = 1'b1;

            checks++;
            if (bus.req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL req_ready cyc%0d: got %b want %b", m_cyc, bus.req_ready, exp_rdy);
            end
            checks++;
            if (bus.can_tx_valid !== m_ov) begin
                errors++;
                $display("FAIL can_tx_valid cyc%0d: got %b want %b", m_cyc, bus.can_tx_valid, m_ov);
            end
            if (m_ov) begin
                checks++;
                if (bus.can_tx_data !== m_data) begin
                    errors++;
                    $display("FAIL can_tx_data cyc%0d: got %h want %h", m_cyc, bus.can_tx_data, m_data);
                end
                checks++;
                if (bus.last_src !== m_src) begin
                    errors++;
                    $display("FAIL last_src cyc%0d: got %h want %h", m_cyc, bus.last_src, m_src);
                end
            end
            checks++;
            if (bus.hb_overrun !== m_ovr) begin
                errors++;
                $display("FAIL hb_overrun cyc%0d: got %b want %b", m_cyc, bus.hb_overrun, m_ovr);
            end

            if (bus.hb_overrun === 1'b1) n_ovr_seen++;
            if (bus.can_tx_valid === 1'b1 && rdy) begin
                out_log.push_back(int'(bus.last_src));
                if (bus.last_src === 4'hF) hb_log.push_back(bus.can_tx_data);
            end

            nxt_ovr = tick && m_pend && !load;
            if (load) begin
                if (m_pend) begin
                    m_ov = 1'b1;
                    m_data = {HB_TAG, m_seq, 16'h0000};
                    m_src = 4'hF;
                    m_seq = m_seq + 8'd1;
                end else if (w >= 0) begin
                    m_ov = 1'b1;
                    m_data = rd[w];
                    m_src = 4'(w);
                    m_ptr = (w + 1) % NREQ;
                    hold[w] = 1'b0;
                end else begin
                    m_ov = 1'b0;
                end
            end
            m_pend = (load && m_pend) ? tick : (m_pend || tick);
            m_ovr = nxt_ovr;
            m_cyc++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.req_valid = '1;
        bus.req_data = {NREQ{32'hDEADBEEF}};
        bus.can_tx_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.can_tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", bus.can_tx_valid);
        end
        checks++;
        if (bus.can_tx_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", bus.can_tx_data);
        end
        checks++;
        if (bus.last_src !== 4'h0) begin
            errors++;
            $display("FAIL reset_src: got %h want 0", bus.last_src);
        end
        checks++;
        if (bus.req_ready !== '0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", bus.req_ready);
        end
        checks++;
        if (bus.hb_overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovr: got %b want 0", bus.hb_overrun);
        end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        bus.req_valid = 4'b0100;
        bus.req_data[95:64] = 32'h11223344;
        bus.can_tx_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b want 0100", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.can_tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_valid: got %b want 1", bus.can_tx_valid);
        end
        checks++;
        if (bus.can_tx_data !== 32'h11223344) begin
            errors++;
            $display("FAIL single_data: got %h want 11223344", bus.can_tx_data);
        end
        checks++;
        if (bus.last_src !== 4'h2) begin
            errors++;
            $display("FAIL single_src: got %h want 2", bus.last_src);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        run_model(9, 100, 100);
        checks++;
        if (out_log.size() != 8) begin
            errors++;
            $display("FAIL rr_count: got %0d want 8", out_log.size());
        end
        for (int i = 0; i < out_log.size(); i++) begin
            checks++;
            if (out_log[i] != i % NREQ) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d want %0d", i, out_log[i], i % NREQ);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] sb[$];
        logic [31:0] hd;
        logic [3:0]  hs;
        logic [31:0] exp_w;
        int          seqn[NREQ];
        do_reset();
        hd = '0;
        hs = '0;
        for (int i = 0; i < NREQ; i++) seqn[i] = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                bus.req_valid[i] = (c < 16);
                bus.req_data[32*i +: 32] = {8'hB0, 8'(i), 16'(seqn[i])};
            end
            bus.can_tx_ready = !(c >= 4 && c < 9);
            #1;
            if (c == 4) begin
                hd = bus.can_tx_data;
                hs = bus.last_src;
            end
            if (c > 4 && c < 9) begin
                checks++;
                if (bus.can_tx_data !== hd || bus.last_src !== hs) begin
                    errors++;
                    $display("FAIL bp_hold c%0d: got %h/%h want %h/%h", c, bus.can_tx_data, bus.last_src, hd, hs);
                end
                checks++;
                if (bus.req_ready !== '0) begin
                    errors++;
                    $display("FAIL bp_ready c%0d: got %b want 0", c, bus.req_ready);
                end
                checks++;
                if (bus.can_tx_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_valid c%0d: got %b want 1", c, bus.can_tx_valid);
                end
            end
            if (bus.can_tx_valid === 1'b1 && bus.can_tx_ready && bus.last_src !== 4'hF) begin
                exp_w = (sb.size() > 0) ? sb.pop_front() : 32'hXXXXXXXX;
                checks++;
                if (bus.can_tx_data !== exp_w) begin
                    errors++;
                    $display("FAIL bp_word c%0d: got %h want %h", c, bus.can_tx_data, exp_w);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i] === 1'b1) begin
                    sb.push_back(bus.req_data[32*i +: 32]);
                    seqn[i]++;
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL bp_lost: got %0d words left want 0", sb.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        run_model(600, 50, 60);
        checks++;
        if (out_log.size() == 0) begin
            errors++;
            $display("FAIL rand_traffic: got 0 transfers want >0");
        end
    endtask

`ifdef CAN_TX_SCHED_HEARTBEAT_EN
    task automatic test_heartbeat();
        int pos[$];
        int e;
        int bad;
        do_reset();
        run_model(40, 100, 100);
        e = 0;
        bad = 0;
        for (int i = 0; i < out_log.size(); i++) begin
            if (out_log[i] == 15) pos.push_back(i);
            else begin
                if (out_log[i] != e % NREQ) bad++;
                e++;
            end
        end
        checks++;
        if (hb_log.size() != 2 || pos.size() != 2) begin
            errors++;
            $display("FAIL hb_count: got %0d want 2", hb_log.size());
        end else begin
            checks++;
            if (hb_log[0] !== 32'hA5000000) begin
                errors++;
                $display("FAIL hb_word0: got %h want a5000000", hb_log[0]);
            end
            checks++;
            if (hb_log[1] !== 32'hA5010000) begin
                errors++;
                $display("FAIL hb_word1: got %h want a5010000", hb_log[1]);
            end
            checks++;
            if (pos[0] != 16 || pos[1] != 32) begin
                errors++;
                $display("FAIL hb_pos: got %0d,%0d want 16,32", pos[0], pos[1]);
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hb_rr_order: got %0d misordered want 0", bad);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        run_model(60, 100, 0);
        checks++;
        if (n_ovr_seen != 2) begin
            errors++;
            $display("FAIL ovr_pulses: got %0d want 2", n_ovr_seen);
        end
        out_log.delete();
        hb_log.delete();
        run_model(3, 0, 100);
        checks++;
        if (hb_log.size() != 1) begin
            errors++;
            $display("FAIL ovr_hb_sent: got %0d want 1", hb_log.size());
        end else begin
            checks++;
            if (hb_log[0] !== 32'hA5000000) begin
                errors++;
                $display("FAIL ovr_hb_word: got %h want a5000000", hb_log[0]);
            end
        end
    endtask
`else
    task automatic test_heartbeat();
        int nf;
        do_reset();
        run_model(60, 100, 100);
        run_model(60, 100, 0);
        nf = 0;
        foreach (out_log[i]) if (out_log[i] == 15) nf++;
        checks++;
        if (nf != 0) begin
            errors++;
            $display("FAIL nohb_src: got %0d heartbeat words want 0", nf);
        end
        checks++;
        if (n_ovr_seen != 0) begin
            errors++;
            $display("FAIL nohb_ovr: got %0d pulses want 0", n_ovr_seen);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int first;
        do_reset();
        run_model(5, 100, 100);
        @(negedge clk);
        bus.req_valid = '1;
        bus.can_tx_ready = 1'b1;
        #1;
        checks++;
        if (bus.can_tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_valid: got %b want 1", bus.can_tx_valid);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.can_tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_valid: got %b want 0", bus.can_tx_valid);
        end
        checks++;
        if (bus.req_ready !== '0) begin
            errors++;
            $display("FAIL mid_ready: got %b want 0", bus.req_ready);
        end
        checks++;
        if (bus.hb_overrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_ovr: got %b want 0", bus.hb_overrun);
        end
        do_reset();
        run_model(30, 100, 100);
        first = (out_log.size() > 0) ? out_log[0] : -1;
        checks++;
        if (first != 0) begin
            errors++;
            $display("FAIL mid_first_grant: got %0d want 0", first);
        end
`ifdef CAN_TX_SCHED_HEARTBEAT_EN
        checks++;
        if (hb_log.size() == 0 || hb_log[0] !== 32'hA5000000) begin
            errors++;
            $display("FAIL mid_first_hb: got %h want a5000000", (hb_log.size() > 0) ? hb_log[0] : 32'h0);
        end
`endif
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.can_tx_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_random();
        test_heartbeat();
`ifdef CAN_TX_SCHED_HEARTBEAT_EN
        test_overrun();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
